// File: rtl/traffic_pkg.sv
// Shared encodings for the two-road traffic controller.
// Used by the controller and the upstream traffic counter.
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        A_STATE    = 3'd1,
        B_STATE    = 3'd2,
        A_IS_GREEN = 3'd3,
        B_IS_GREEN = 3'd4,
        BLINK      = 3'd5
    } tl_state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Flashing amber: yellow lamp follows the blink phase.
    function automatic logic [2:0] blink_lamp(input logic phase);
        return {1'b0, phase, 1'b0};
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Sensor/count inputs and lamp/state outputs of the controller.
// master = upstream counter and sensors, slave = controller.
interface traffic_light_fsm_if;

    logic       A_Traffic;
    logic       B_Traffic;
    logic [6:0] Traffic_gone;
    logic [3:0] Traffic_Back;
    logic [2:0] state;
    logic [2:0] A_Light;
    logic [2:0] B_Light;
    logic       Blink_on;

    modport master (
        output A_Traffic,
        output B_Traffic,
        output Traffic_gone,
        output Traffic_Back,
        input  state,
        input  A_Light,
        input  B_Light,
        input  Blink_on
    );

    modport slave (
        input  A_Traffic,
        input  B_Traffic,
        input  Traffic_gone,
        input  Traffic_Back,
        output state,
        output A_Light,
        output B_Light,
        output Blink_on
    );

endinterface

// File: rtl/traffic_timer.sv
// In-state cycle timer: sync clear, count enable,
// saturates at all-ones so long greens never wrap.
module traffic_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Clear wins over counting; hold once all-ones is reached.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic controller: green/yellow alternation with
// min/max green, plus flashing-yellow mode when traffic is gone.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int TMR_W      = 8,
    parameter int ALLRED_CYC = 2,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 40,
    parameter int YELLOW_CYC = 4,
    parameter int GONE_LIMIT = 100,
    parameter int BACK_LIMIT = 8,
    parameter int BLINK_HALF = 5
) (
    input  logic               CLK,
    input  logic               Reset,
    traffic_light_fsm_if.slave tl
);

    localparam logic [TMR_W-1:0] ALLRED_LAST = TMR_W'(ALLRED_CYC - 1);
    localparam logic [TMR_W-1:0] GMIN_LAST   = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] GMAX_LAST   = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] YEL_LAST    = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] HALF_LAST   = TMR_W'(BLINK_HALF - 1);
    localparam logic [6:0]       GONE_TH     = 7'(GONE_LIMIT);
    localparam logic [3:0]       BACK_TH     = 4'(BACK_LIMIT);

    tl_state_e        state_q;
    tl_state_e        next_state;
    logic [TMR_W-1:0] timer;
    logic             tmr_clr;
    logic             blink_pend;
    logic             pend_nxt;
    logic             blink_phase;
    logic             phase_nxt;
    logic             blink_wrap;
    logic             gone_hit;
    logic             back_hit;
    logic             green_min;
    logic             green_max;
    logic [2:0]       a_lamp;
    logic [2:0]       b_lamp;
    logic             blink_on;

    // >= compares: upstream counters may run past the limit.
    assign gone_hit   = (tl.Traffic_gone >= GONE_TH);
    assign back_hit   = (tl.Traffic_Back >= BACK_TH);
    assign green_min  = (timer >= GMIN_LAST);
    assign green_max  = (timer >= GMAX_LAST);
    assign blink_wrap = (state_q == BLINK) && (timer == HALF_LAST);

    // Timer restarts on any state change and at each blink half-period.
    assign tmr_clr = (next_state != state_q) || blink_wrap;

    traffic_timer #(
        .W(TMR_W)
    ) u_timer (
        .CLK  (CLK),
        .Reset(Reset),
        .clr  (tmr_clr),
        .en   (1'b1),
        .count(timer)
    );

    // Next-state selection and blink_pend update.
    always_comb begin
        next_state = state_q;
        pend_nxt   = blink_pend;
        unique case (state_q)
            INIT: begin
                if (timer == ALLRED_LAST) begin
                    next_state = A_IS_GREEN;
                end
            end
            A_IS_GREEN: begin
                if (green_min) begin
                    if (gone_hit) begin
                        next_state = A_STATE;
                        pend_nxt   = 1'b1;
                    end else if (tl.B_Traffic &&
                                 (!tl.A_Traffic || green_max)) begin
                        next_state = A_STATE;
                    end
                end
            end
            B_IS_GREEN: begin
                if (green_min) begin
                    if (gone_hit) begin
                        next_state = B_STATE;
                        pend_nxt   = 1'b1;
                    end else if (tl.A_Traffic &&
                                 (!tl.B_Traffic || green_max)) begin
                        next_state = B_STATE;
                    end
                end
            end
            A_STATE: begin
                if (timer == YEL_LAST) begin
                    next_state = blink_pend ? BLINK : B_IS_GREEN;
                    pend_nxt   = 1'b0;
                end
            end
            B_STATE: begin
                if (timer == YEL_LAST) begin
                    next_state = blink_pend ? BLINK : A_IS_GREEN;
                    pend_nxt   = 1'b0;
                end
            end
            BLINK: begin
                if (back_hit) begin
                    next_state = INIT;
                end
            end
            default: begin
                next_state = INIT;
                pend_nxt   = 1'b0;
            end
        endcase
    end

    // Blink phase: lit on entry, toggles every half-period, dark outside BLINK.
    always_comb begin
        phase_nxt = 1'b0;
        if (next_state == BLINK) begin
            if (state_q != BLINK) begin
                phase_nxt = 1'b1;
            end else if (blink_wrap) begin
                phase_nxt = ~blink_phase;
            end else begin
                phase_nxt = blink_phase;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= INIT;
            blink_pend  <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            state_q     <= next_state;
            blink_pend  <= pend_nxt;
            blink_phase <= phase_nxt;
        end
    end

    // Moore lamp decode; illegal codes show all-red.
    always_comb begin
        a_lamp   = RED;
        b_lamp   = RED;
        blink_on = 1'b0;
        unique case (state_q)
            INIT: begin
                a_lamp = RED;
                b_lamp = RED;
            end
            A_IS_GREEN: a_lamp = GRN;
            B_IS_GREEN: b_lamp = GRN;
            A_STATE:    a_lamp = YEL;
            B_STATE:    b_lamp = YEL;
            BLINK: begin
                a_lamp   = blink_lamp(blink_phase);
                b_lamp   = blink_lamp(blink_phase);
                blink_on = 1'b1;
            end
            default: begin
                a_lamp = RED;
                b_lamp = RED;
            end
        endcase
    end

    assign tl.state    = state_q;
    assign tl.A_Light  = a_lamp;
    assign tl.B_Light  = b_lamp;
    assign tl.Blink_on = blink_on;

endmodule
